// File: rtl/gate_op_pkg.sv
// Shared opcode constants and FSM state
// encoding for the gate operation scheduler.
package gate_op_pkg;

  localparam logic [2:0] OP_NOT  = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_VALID = 1'b1
  } state_e;

endpackage

// File: rtl/gate_unit.sv
// Combinational bitwise gate evaluator.
// Reserved opcode yields zero and flags err.
module gate_unit #(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             err
);
  import gate_op_pkg::*;

  // decode opcode into the bitwise result
  always_comb begin
    y   = '0;
    err = 1'b0;
    case (op)
      OP_NOT:  y = ~a;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/gate_op_scheduler.sv
// Round-robin arbiter sharing one gate unit
// among N_REQ requesters, result handshake.
module gate_op_scheduler #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [3*N_REQ-1:0]       op,
  input  logic [WIDTH*N_REQ-1:0]   a,
  input  logic [WIDTH*N_REQ-1:0]   b,
  output logic [N_REQ-1:0]         gnt,
  output logic                     res_valid,
  output logic [WIDTH-1:0]         res_data,
  output logic [$clog2(N_REQ)-1:0] res_id,
  output logic                     res_err,
  input  logic                     res_ready
);
  import gate_op_pkg::*;

  localparam int IDW = $clog2(N_REQ);
  localparam logic [IDW:0] NW =
    (IDW+1)'(N_REQ);
  localparam logic [IDW-1:0] LAST =
    IDW'(N_REQ - 1);

  state_e           state;
  state_e           state_n;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   win;
  logic             found;
  logic [IDW:0]     scan;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] y;
  logic             err;
  logic             load;
  logic             clear;

  // first set request at or after ptr wins
  always_comb begin
    found = 1'b0;
    win   = '0;
    scan  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan = {1'b0, ptr} + (IDW+1)'(k);
      if (scan >= NW)
        scan = scan - NW;
      if (!found && req[scan]) begin
        found = 1'b1;
        win   = scan[IDW-1:0];
      end
    end
  end

  assign sel_op = op[3*int'(win) +: 3];
  assign sel_a  = a[WIDTH*int'(win) +: WIDTH];
  assign sel_b  = b[WIDTH*int'(win) +: WIDTH];

  gate_unit #(.WIDTH(WIDTH)) u_gate (
    .op  (sel_op),
    .a   (sel_a),
    .b   (sel_b),
    .y   (y),
    .err (err)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_n;
  end

  // next state and load/clear strobes
  always_comb begin
    state_n = state;
    load    = 1'b0;
    clear   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (found) begin
          load    = 1'b1;
          state_n = ST_VALID;
        end
      end
      ST_VALID: begin
        if (res_ready) begin
          clear   = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // grant pulse, result capture and ptr advance
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      gnt       <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
      res_err   <= 1'b0;
    end else begin
      gnt <= '0;
      if (load) begin
        gnt       <= {{(N_REQ-1){1'b0}}, 1'b1}
                     << win;
        res_valid <= 1'b1;
        res_data  <= y;
        res_id    <= win;
        res_err   <= err;
      end else if (clear) begin
        res_valid <= 1'b0;
        res_data  <= '0;
        res_id    <= '0;
        res_err   <= 1'b0;
        ptr       <= (res_id == LAST) ? '0
                     : res_id + 1'b1;
      end
    end
  end

endmodule

// File: doc/gate_op_scheduler.md
GATE_OP_SCHEDULER -- requirements
Module: gate_op_scheduler

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the gate unit (2..8).
REQ-002 Parameter WIDTH, default 8, operand/result width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req  input  N_REQ  per-requester request, level, held until its gnt.
REQ-006 op  input  3*N_REQ  per-requester opcode, slice i = op[3i+2:3i].
REQ-007 a  input  WIDTH*N_REQ  per-requester operand A, slice i = a[WIDTH*i +: WIDTH].
REQ-008 b  input  WIDTH*N_REQ  per-requester operand B, same slicing.
REQ-009 gnt  output  N_REQ  one-hot grant, one-cycle pulse; operands captured.
REQ-010 res_valid  output  1  result available.
REQ-011 res_data  output  WIDTH  registered result.
REQ-012 res_id  output  clog2(N_REQ)  index of requester owning res_data.
REQ-013 res_err  output  1  opcode was reserved (7).
REQ-014 res_ready  input  1  consumer accepts result.

Function
REQ-015 Opcodes SHALL be bitwise: 0 NOT A, 1 AND, 2 OR, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 reserved -> res_data 0, res_err 1.
REQ-016 FSM SHALL have two states: IDLE, VALID.
REQ-017 IDLE with no req bit set SHALL remain IDLE; outputs hold reset values.
REQ-018 IDLE with any req bit set at edge k SHALL select winner by round-robin from pointer ptr, capture winner's op/a/b, register result, move to VALID.
REQ-019 In cycle after edge k: gnt[winner]=1 for exactly one cycle, res_valid=1, res_data/res_id/res_err stable.
REQ-020 VALID SHALL hold res_valid and all result outputs unchanged while res_ready=0.
REQ-021 VALID with res_ready=1 at an edge SHALL clear res_valid, set ptr=(winner+1) mod N_REQ, return IDLE; no new grant on that same edge.
REQ-022 Minimum throughput: one operation per two cycles; latency req-to-res_valid = 1 cycle.
REQ-023 Round-robin: search order ptr, ptr+1, ..., wrapping at N_REQ-1 -> 0; first set req bit wins.
REQ-024 req changes during VALID SHALL be ignored; operands used are those captured at grant edge.
REQ-025 res_ready asserted in IDLE SHALL have no effect.
REQ-026 NOT (op 0) SHALL ignore operand B.
REQ-027 res_id SHALL be 0 and res_err 0 whenever res_valid=0.

Reset
REQ-028 rst=1 at an edge SHALL force state IDLE, ptr=0, gnt=0, res_valid=0, res_data=0, res_id=0, res_err=0, regardless of state.
REQ-029 Reset asserted in VALID SHALL discard the pending result without further grant; requester must re-request.
REQ-030 Reset has priority over all other inputs on the same edge.

Structure
REQ-031 Opcode constants (OP_NOT..OP_XNOR, OP_RSVD) and state encodings SHALL live in a shared package/include, gate_op_pkg.
REQ-032 Bitwise evaluation SHALL be a combinational sub-module gate_unit (inputs op, a, b; outputs y, err), instantiated once.
REQ-033 Round-robin select and FSM SHALL reside in gate_op_scheduler; no other sub-modules.

Verification (N_REQ=4, WIDTH=8)
REQ-034 Reset then req=0001, op0=1, a0=8'hF0, b0=8'h3C, res_ready=1 -> next cycle gnt=0001, res_valid=1, res_data=8'h30, res_id=0, res_err=0.
REQ-035 req=1111 held, res_ready=1, ops=5 with a=8'hAA, b=8'h0F -> grants 0001,0010,0100,1000,0001 on alternate cycles; res_data=8'hA5 each.
REQ-036 op2=7, req=0100 -> res_valid=1, res_err=1, res_data=0, res_id=2.
REQ-037 Grant to req0, res_ready=0 for 5 cycles, a0 changed meanwhile -> res_data unchanged, no further gnt; release res_ready -> IDLE next cycle.
REQ-038 rst=1 during VALID -> next cycle all outputs 0, ptr=0; subsequent req=1010 grants requester 1 first.
REQ-039 op0=0, a0=8'h5A, b0=8'hFF -> res_data=8'hA5 (B ignored).
